// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, PC redirect mux and
// hardware return-address stack for the 19-bit pipelined core.
module fetch_stage #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SPW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [1:0]    pc_mux,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] imem_addr,
  input  logic [18:0]   imem_data,
  output logic [18:0]   id_instr,
  output logic [AW-1:0] id_pc,
  output logic          id_valid,
  output logic          stk_ovf,
  output logic          stk_unf
);

  localparam int unsigned CW = SPW + 1;
  localparam logic [1:0] MUX_SEQ = 2'b00;
  localparam logic [1:0] MUX_BR  = 2'b01;
  localparam logic [1:0] MUX_JMP = 2'b10;
  localparam logic [1:0] MUX_RET = 2'b11;

  logic [AW-1:0]  pc;
  logic [SPW-1:0] sp;
  logic [CW-1:0]  count;
  logic [AW-1:0]  stack_mem [DEPTH];

  logic          act_c;
  logic          do_push_c;
  logic          do_pop_c;
  logic          stk_full_c;
  logic          stk_empty_c;
  logic          redirect_c;
  logic [AW-1:0] ret_addr_c;
  logic [AW-1:0] top_c;
  logic [AW-1:0] target_c;

  assign imem_addr = pc;

  // Control decode and next-PC selection; the ID instruction only acts when real and unstalled
  always_comb begin
    act_c       = id_valid & ~stall;
    do_push_c   = act_c & push;
    do_pop_c    = act_c & pop & ~push;
    stk_full_c  = (count == CW'(DEPTH));
    stk_empty_c = (count == '0);
    ret_addr_c  = id_pc + AW'(1);
    top_c       = stk_empty_c ? '0 : stack_mem[sp - SPW'(1)];
    redirect_c  = act_c & (pc_mux != MUX_SEQ);
    target_c    = pc + AW'(1);
    if (redirect_c) begin
      case (pc_mux)
        MUX_BR:  target_c = ret_addr_c + AW'($signed(id_instr[7:0]));
        MUX_JMP: target_c = id_instr[AW-1:0];
        MUX_RET: target_c = top_c;
        default: target_c = pc + AW'(1);
      endcase
    end
  end

  // PC, IF/ID register, stack pointer and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      id_instr <= '0;
      id_pc    <= '0;
      id_valid <= 1'b0;
      sp       <= '0;
      count    <= '0;
      stk_ovf  <= 1'b0;
      stk_unf  <= 1'b0;
    end else if (!stall) begin
      pc    <= target_c;
      id_pc <= pc;
      if (redirect_c) begin
        id_valid <= 1'b0;
        id_instr <= '0;
      end else begin
        id_valid <= 1'b1;
        id_instr <= imem_data;
      end
      if (do_push_c) begin
        sp <= sp + SPW'(1);
        if (stk_full_c) stk_ovf <= 1'b1;
        else            count   <= count + CW'(1);
      end else if (do_pop_c) begin
        if (stk_empty_c) begin
          stk_unf <= 1'b1;
        end else begin
          sp    <= sp - SPW'(1);
          count <= count - CW'(1);
        end
      end
    end
  end

  // Stack storage needs no reset; a full push overwrites the oldest entry
  always_ff @(posedge clk) begin
    if (!reset && do_push_c) stack_mem[sp] <= ret_addr_c;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus randomized
// controller traffic compared against a queue-based reference model.
module tb_fetch_stage;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned N     = 1 << AW;

  logic          clk;
  logic          reset;
  logic          stall;
  logic [1:0]    pc_mux;
  logic          push;
  logic          pop;
  logic [AW-1:0] imem_addr;
  logic [18:0]   imem_data;
  logic [18:0]   id_instr;
  logic [AW-1:0] id_pc;
  logic          id_valid;
  logic          stk_ovf;
  logic          stk_unf;

  logic [18:0] rom [N];
  assign imem_data = rom[imem_addr];

  fetch_stage #(.AW(AW), .DEPTH(DEPTH), .SPW(3)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_mux(pc_mux),
    .push(push), .pop(pop), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned pc;
    bit          iv;
    int unsigned ii;
    int unsigned ipc;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int unsigned m_pc, m_ii, m_ipc;
  bit          m_iv, m_ovf, m_unf;
  int unsigned stk[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT against the oldest expected state after every edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("imem_addr", 32'(imem_addr), e.pc);
      chk("id_valid", 32'(id_valid), 32'(e.iv));
      chk("id_instr", 32'(id_instr), e.ii);
      if (e.iv) chk("id_pc", 32'(id_pc), e.ipc);
      chk("stk_ovf", 32'(stk_ovf), 32'(e.ovf));
      chk("stk_unf", 32'(stk_unf), 32'(e.unf));
    end
  end

  // Drive one cycle of controller inputs, advance the model, queue the expectation
  task automatic step(input bit r, input bit s, input logic [1:0] m, input bit pu, input bit po);
    int unsigned tgt, top;
    int          off;
    bit          redir;
    exp_t        e;
    reset = r; stall = s; pc_mux = m; push = pu; pop = po;
    if (r) begin
      m_pc = 0; m_iv = 0; m_ii = 0; m_ipc = 0; m_ovf = 0; m_unf = 0;
      stk.delete();
    end else if (!s) begin
      top   = 0;
      tgt   = (m_pc + 1) % N;
      redir = m_iv && (m != 2'b00);
      if (m_iv && pu) begin
        stk.push_back((m_ipc + 1) % N);
        if (stk.size() > DEPTH) begin
          void'(stk.pop_front());
          m_ovf = 1;
        end
      end else if (m_iv && po) begin
        if (stk.size() == 0) m_unf = 1;
        else top = stk.pop_back();
      end
      if (redir) begin
        off = (m_ii & 32'h80) != 0 ? int'(m_ii & 32'hFF) - 256 : int'(m_ii & 32'hFF);
        case (m)
          2'b01:   tgt = unsigned'(int'(m_ipc) + 1 + off + int'(N)) % N;
          2'b10:   tgt = m_ii % N;
          default: tgt = top;
        endcase
      end
      m_ipc = m_pc;
      m_ii  = redir ? 0 : int'(rom[m_pc]);
      m_iv  = !redir;
      m_pc  = tgt;
    end
    e.pc = m_pc; e.iv = m_iv; e.ii = m_ii; e.ipc = m_ipc; e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Reset, then jump via ROM[0] so that address a sits in IF/ID
  task automatic goto_addr(input int unsigned a);
    rom[0] = 19'(a);
    step(1, 0, 2'b00, 0, 0);
    step(0, 0, 2'b00, 0, 0);
    step(0, 0, 2'b10, 0, 0);
    step(0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    int unsigned kind;
    reset = 1; stall = 0; pc_mux = 0; push = 0; pop = 0;
    for (int i = 0; i < int'(N); i++) rom[i] = 19'($urandom);
    @(negedge clk);

    // Sequential fetch out of reset
    rom[0] = 19'h0000A; rom[1] = 19'h0000B; rom[2] = 19'h0000C; rom[3] = 19'h0000D;
    step(1, 0, 2'b00, 0, 0);
    chk("t1_reset_valid", 32'(id_valid), 32'd0);
    chk("t1_reset_addr", 32'(imem_addr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 2'b00, 0, 0);
      chk("t1_id_pc", 32'(id_pc), 32'(i));
      chk("t1_valid", 32'(id_valid), 32'd1);
    end
    chk("t1_instr_d", 32'(id_instr), 32'h0000D);

    // Absolute jump with a single bubble
    rom[5] = 19'h00040;
    goto_addr(5);
    chk("t2_id_pc", 32'(id_pc), 32'h005);
    step(0, 0, 2'b10, 0, 0);
    chk("t2_bubble", 32'(id_valid), 32'd0);
    chk("t2_bubble_instr", 32'(id_instr), 32'd0);
    step(0, 0, 2'b00, 0, 0);
    chk("t2_target", 32'(id_pc), 32'h040);

    // Backward branch taken, then not taken
    rom[16] = 19'h000FE;
    goto_addr(16);
    step(0, 0, 2'b01, 0, 0);
    chk("t3_br_pc", 32'(imem_addr), 32'h00F);
    goto_addr(16);
    step(0, 0, 2'b00, 0, 0);
    chk("t3_seq_pc", 32'(imem_addr), 32'h012);
    chk("t3_seq_valid", 32'(id_valid), 32'd1);

    // JSB / RET round trip
    rom[32] = 19'h00100;
    goto_addr(32);
    step(0, 0, 2'b10, 1, 0);
    chk("t4_jsb_pc", 32'(imem_addr), 32'h100);
    for (int i = 0; i < 4; i++) step(0, 0, 2'b00, 0, 0);
    chk("t4_ret_site", 32'(id_pc), 32'h103);
    step(0, 0, 2'b11, 0, 1);
    chk("t4_ret_pc", 32'(imem_addr), 32'h021);
    step(0, 0, 2'b00, 0, 0);
    chk("t4_after_ret", 32'(id_pc), 32'h021);
    chk("t4_next_pc", 32'(imem_addr), 32'h022);

    // Nine nested calls overflow an 8-deep stack, then unwind past empty
    for (int k = 0; k < 9; k++) rom[32'h200 + 16 * k] = 19'(32'h200 + 16 * (k + 1));
    goto_addr(32'h200);
    for (int k = 0; k < 9; k++) begin
      step(0, 0, 2'b10, 1, 0);
      chk("t5_ovf", 32'(stk_ovf), (k == 8) ? 32'd1 : 32'd0);
      step(0, 0, 2'b00, 0, 0);
    end
    for (int k = 8; k >= 1; k--) begin
      step(0, 0, 2'b11, 0, 1);
      chk("t5_ret_pc", 32'(imem_addr), 32'(32'h200 + 16 * k + 1));
      step(0, 0, 2'b00, 0, 0);
    end
    chk("t5_unf_before", 32'(stk_unf), 32'd0);
    step(0, 0, 2'b11, 0, 1);
    chk("t5_unf", 32'(stk_unf), 32'd1);
    chk("t5_unf_pc", 32'(imem_addr), 32'd0);

    // Stall holds a pending branch; reset overrides stall
    rom[48] = 19'h00005;
    goto_addr(48);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b01, 0, 0);
      chk("t6_hold_pc", 32'(imem_addr), 32'h031);
      chk("t6_hold_id", 32'(id_pc), 32'h030);
    end
    step(0, 0, 2'b01, 0, 0);
    chk("t6_br_pc", 32'(imem_addr), 32'h036);
    step(1, 1, 2'b00, 0, 0);
    chk("t6_rst_valid", 32'(id_valid), 32'd0);
    chk("t6_rst_pc", 32'(imem_addr), 32'd0);

    // Randomized controller traffic
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(299) == 0) begin
        step(1, 0, 2'b00, 0, 0);
      end else if (!m_iv) begin
        step(0, $urandom_range(4) == 0, 2'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        kind = $urandom_range(5);
        case (kind)
          2:       step(0, $urandom_range(4) == 0, 2'b01, 0, 0);
          3:       step(0, $urandom_range(4) == 0, 2'b10, 0, 0);
          4:       step(0, $urandom_range(4) == 0, 2'b10, 1, 0);
          5:       step(0, $urandom_range(4) == 0, 2'b11, 0, 1);
          default: step(0, $urandom_range(4) == 0, 2'b00, 0, 0);
        endcase
      end
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
